mem_arbiter: RTL

//  Shares the single synchronous-read word RAM between two requesters: port 0 (CPU, fetch+load/store)
//  and port 1 (loader/debug writer). Captures one request per port, grants round-robin (or fixed),

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous-read word RAM.
// Ports: CLK/RESET, p0_*/p1_* requesters, mem_* RAM side, grant owner.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [31:0]       p0_wdata,
   input  logic [3:0]        p0_wmask,
   input  logic              p0_rstrb,
   output logic              p0_busy,
   output logic              p0_done,
   output logic [31:0]       p0_rdata,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [31:0]       p1_wdata,
   input  logic [3:0]        p1_wmask,
   input  logic              p1_rstrb,
   output logic              p1_busy,
   output logic              p1_done,
   output logic [31:0]       p1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wmask,
   output logic              mem_rstrb,
   input  logic [31:0]       mem_rdata,
   output logic              grant
);

   typedef enum logic {S_IDLE, S_RESP} state_e;

   state_e state_q, state_d;

   logic [1:0][ADDR_W-1:0] addr_q;
   logic [1:0][31:0]       wdata_q;
   logic [1:0][3:0]        wmask_q;
   logic [1:0]             wr_q;
   logic [1:0]             pend_q;
   logic [1:0]             done_q;
   logic [1:0][31:0]       rdata_q;
   logic                   grant_q;
   logic                   last_q;

   logic [1:0][ADDR_W-1:0] in_addr;
   logic [1:0][31:0]       in_wdata;
   logic [1:0][3:0]        in_wmask;
   logic [1:0]             req;
   logic                   sel;

   assign in_addr  = {p1_addr, p0_addr};
   assign in_wdata = {p1_wdata, p0_wdata};
   assign in_wmask = {p1_wmask, p0_wmask};
   assign req[0]   = p0_rstrb | (|p0_wmask);
   assign req[1]   = p1_rstrb | (|p1_wmask);

   // Outside an IDLE grant, sel follows grant_q so the RAM
   // address/data lines keep showing the granted capture.
   always_comb begin
      state_d   = state_q;
      sel       = grant_q;
      mem_wmask = 4'b0000;
      mem_rstrb = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (|pend_q) begin
               if (&pend_q) begin
                  sel = FIXED_PRIO ? 1'b0 : ~last_q;
               end else begin
                  sel = pend_q[1];
               end
               mem_wmask = wr_q[sel] ? wmask_q[sel] : 4'b0000;
               mem_rstrb = ~wr_q[sel];
               state_d   = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_addr  = addr_q[sel];
   assign mem_wdata = wdata_q[sel];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         wr_q    <= '0;
         pend_q  <= '0;
         done_q  <= '0;
         rdata_q <= '0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         done_q  <= '0;
         for (int n = 0; n < 2; n++) begin
            if (!pend_q[n] && req[n]) begin
               addr_q[n]  <= in_addr[n];
               wdata_q[n] <= in_wdata[n];
               wmask_q[n] <= in_wmask[n];
               wr_q[n]    <= |in_wmask[n];
               pend_q[n]  <= 1'b1;
            end
         end
         if (state_q == S_IDLE && (|pend_q)) begin
            grant_q <= sel;
            last_q  <= sel;
         end
         // Completion only clears the granted port; a pending
         // request on the other port stays queued.
         if (state_q == S_RESP) begin
            if (!wr_q[grant_q]) begin
               rdata_q[grant_q] <= mem_rdata;
            end
            done_q[grant_q] <= 1'b1;
            pend_q[grant_q] <= 1'b0;
         end
      end
   end

   assign p0_busy  = pend_q[0];
   assign p1_busy  = pend_q[1];
   assign p0_done  = done_q[0];
   assign p1_done  = done_q[1];
   assign p0_rdata = rdata_q[0];
   assign p1_rdata = rdata_q[1];
   assign grant    = grant_q;

endmodule
